// File: rtl/bcd_counter_4dig.sv
// rtl/bcd_counter_4dig.sv - 4-digit BCD up/down counter with tick prescaler, preset and wrap pulse
// Optional COUNTER_HEX_MODE_EN: digits count 0..F and load_val is taken unclamped.
module bcd_counter_4dig #(
  parameter int TICK_DIV = 50_000_000,
  parameter int PRE_W    = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        up_dn,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] digits,
  output logic        tick,
  output logic        wrap
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

`ifdef COUNTER_HEX_MODE_EN
  localparam logic [3:0] MAXD = 4'hF;
`else
  localparam logic [3:0] MAXD = 4'd9;
`endif

  logic [PRE_W-1:0] pre;
  logic [15:0]      next_digits;
  logic [15:0]      load_digits;
  logic             all_carry;

  // Ripple carry/borrow from d0 upward; a carry out of d3 means the count wrapped.
  always_comb begin
    logic [3:0] d;
    logic       carry;
    next_digits = digits;
    carry       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = digits[i*4 +: 4];
      if (carry) begin
        if (up_dn) begin
          if (d >= MAXD) begin
            d = 4'd0;
          end else begin
            d     = d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            d = MAXD;
          end else begin
            d     = d - 4'd1;
            carry = 1'b0;
          end
        end
      end
      next_digits[i*4 +: 4] = d;
    end
    all_carry = carry;
  end

  always_comb begin
    load_digits = load_val;
`ifndef COUNTER_HEX_MODE_EN
    for (int i = 0; i < 4; i++) begin
      if (load_val[i*4 +: 4] > MAXD) begin
        load_digits[i*4 +: 4] = MAXD;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre    <= '0;
      digits <= 16'h0000;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else if (load) begin
      pre    <= '0;
      digits <= load_digits;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else if (en) begin
      if (pre == PRE_MAX) begin
        pre    <= '0;
        digits <= next_digits;
        tick   <= 1'b1;
        wrap   <= all_carry;
      end else begin
        pre  <= pre + PRE_W'(1);
        tick <= 1'b0;
        wrap <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_counter_4dig.sv
// tb/tb_bcd_counter_4dig.sv - directed self-checking bench for bcd_counter_4dig (TICK_DIV=4, decimal build)
module tb_bcd_counter_4dig;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        up_dn;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] digits;
  logic        tick;
  logic        wrap;

  int errors = 0;
  int checks = 0;

  bcd_counter_4dig #(.TICK_DIV(4), .PRE_W(26)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .digits   (digits),
    .tick     (tick),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // Advance n clock edges; outputs are sampled 1 ns after the last edge.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    load_val = v;
    run(1);
    load     = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 16'h0000;
    run(3);
    checks++;
    if (digits !== 16'h0000 || tick !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset: digits=%h tick=%b wrap=%b, required 0000/0/0", digits, tick, wrap);
    end
    rst_n = 1'b1;
    run(1);
  endtask

  task automatic test_up_count;
    logic [15:0] exp_d;
    logic        exp_t;
    en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      run(1);
      exp_t = (k % 4 == 0);
      exp_d = 16'(k / 4);
      checks++;
      if (digits !== exp_d || tick !== exp_t || wrap !== 1'b0) begin
        errors++;
        $display("FAIL up_count[%0d]: digits=%h tick=%b wrap=%b, required %h/%b/0", k, digits, tick, wrap, exp_d, exp_t);
      end
    end
    do_load(16'h0009);
    run(4);
    checks++;
    if (digits !== 16'h0010 || tick !== 1'b1) begin
      errors++;
      $display("FAIL carry_0009: digits=%h tick=%b, required 0010/1", digits, tick);
    end
    do_load(16'h0099);
    run(4);
    checks++;
    if (digits !== 16'h0100 || tick !== 1'b1) begin
      errors++;
      $display("FAIL carry_0099: digits=%h tick=%b, required 0100/1", digits, tick);
    end
  endtask

  task automatic test_wrap;
    en = 1'b1; up_dn = 1'b1;
    do_load(16'h9999);
    run(3);
    checks++;
    if (digits !== 16'h9999 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_up_pre: digits=%h wrap=%b, required 9999/0", digits, wrap);
    end
    run(1);
    checks++;
    if (digits !== 16'h0000 || wrap !== 1'b1 || tick !== 1'b1) begin
      errors++;
      $display("FAIL wrap_up: digits=%h wrap=%b tick=%b, required 0000/1/1", digits, wrap, tick);
    end
    run(1);
    checks++;
    if (wrap !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL wrap_up_pulse: wrap=%b tick=%b, required 0/0", wrap, tick);
    end
    up_dn = 1'b0;
    do_load(16'h0000);
    run(4);
    checks++;
    if (digits !== 16'h9999 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_down: digits=%h wrap=%b, required 9999/1", digits, wrap);
    end
    run(4);
    checks++;
    if (digits !== 16'h9998 || wrap !== 1'b0 || tick !== 1'b1) begin
      errors++;
      $display("FAIL down_step: digits=%h wrap=%b tick=%b, required 9998/0/1", digits, wrap, tick);
    end
    do_load(16'h0100);
    run(4);
    checks++;
    if (digits !== 16'h0099 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL borrow_0100: digits=%h wrap=%b, required 0099/0", digits, wrap);
    end
    // direction change mid-period must not disturb the prescaler phase
    up_dn = 1'b1;
    do_load(16'h0200);
    run(2);
    up_dn = 1'b0;
    run(1);
    checks++;
    if (digits !== 16'h0200 || tick !== 1'b0) begin
      errors++;
      $display("FAIL updn_mid_hold: digits=%h tick=%b, required 0200/0", digits, tick);
    end
    run(1);
    checks++;
    if (digits !== 16'h0199 || tick !== 1'b1) begin
      errors++;
      $display("FAIL updn_mid_step: digits=%h tick=%b, required 0199/1", digits, tick);
    end
    up_dn = 1'b1;
  endtask

  task automatic test_load;
    en = 1'b1; up_dn = 1'b1;
    do_load(16'h1000);
    run(3);
    do_load(16'h1234);
    checks++;
    if (digits !== 16'h1234 || tick !== 1'b0) begin
      errors++;
      $display("FAIL load_on_step: digits=%h tick=%b, required 1234/0", digits, tick);
    end
    run(3);
    checks++;
    if (digits !== 16'h1234 || tick !== 1'b0) begin
      errors++;
      $display("FAIL load_hold: digits=%h tick=%b, required 1234/0", digits, tick);
    end
    run(1);
    checks++;
    if (digits !== 16'h1235 || tick !== 1'b1) begin
      errors++;
      $display("FAIL load_next: digits=%h tick=%b, required 1235/1", digits, tick);
    end
    en = 1'b0;
    do_load(16'h00A7);
    checks++;
    if (digits !== 16'h0097) begin
      errors++;
      $display("FAIL load_clamp: digits=%h, required 0097", digits);
    end
    do_load(16'hFCB3);
    checks++;
    if (digits !== 16'h9993) begin
      errors++;
      $display("FAIL load_clamp_all: digits=%h, required 9993", digits);
    end
    en = 1'b1;
  endtask

  task automatic test_freeze;
    en = 1'b1; up_dn = 1'b1;
    do_load(16'h0500);
    run(2);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      run(1);
      checks++;
      if (digits !== 16'h0500 || tick !== 1'b0) begin
        errors++;
        $display("FAIL freeze[%0d]: digits=%h tick=%b, required 0500/0", k, digits, tick);
      end
    end
    en = 1'b1;
    run(1);
    checks++;
    if (digits !== 16'h0500 || tick !== 1'b0) begin
      errors++;
      $display("FAIL freeze_resume1: digits=%h tick=%b, required 0500/0", digits, tick);
    end
    run(1);
    checks++;
    if (digits !== 16'h0501 || tick !== 1'b1) begin
      errors++;
      $display("FAIL freeze_resume2: digits=%h tick=%b, required 0501/1", digits, tick);
    end
  endtask

  task automatic test_async_reset;
    en = 1'b1; up_dn = 1'b1;
    do_load(16'h0042);
    run(4);
    checks++;
    if (digits !== 16'h0043 || tick !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: digits=%h tick=%b, required 0043/1", digits, tick);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (digits !== 16'h0000 || tick !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: digits=%h tick=%b wrap=%b, required 0000/0/0", digits, tick, wrap);
    end
    run(1);
    rst_n = 1'b1;
    run(3);
    checks++;
    if (digits !== 16'h0000 || tick !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_hold: digits=%h tick=%b, required 0000/0", digits, tick);
    end
    run(1);
    checks++;
    if (digits !== 16'h0001 || tick !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_step: digits=%h tick=%b, required 0001/1", digits, tick);
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_wrap();
    test_load();
    test_freeze();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
